// File: rtl/eda_output_reader_if.sv
// Output word stream of the flag-matrix reader: packed flags, word index and last marker.
// A word transfers on any rising clk edge where dout_valid and dout_ready are both high; once
// raised, dout_valid and its payload hold steady until that transfer (clear/reset excepted).
interface eda_output_reader_if #(
    parameter int M          = 4,
    parameter int N          = 4,
    parameter int WORD_WIDTH = 8
);
    localparam int NUM_WORDS = (M * N + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int IDX_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    logic                  dout_valid;
    logic                  dout_ready;
    logic [WORD_WIDTH-1:0] dout_data;
    logic [IDX_WIDTH-1:0]  dout_idx;
    logic                  dout_last;

    modport master (
        output dout_valid, dout_data, dout_idx, dout_last,
        input  dout_ready
    );

    modport slave (
        input  dout_valid, dout_data, dout_idx, dout_last,
        output dout_ready
    );
endinterface

// File: rtl/eda_output_reader.sv
// Snapshots the M x N regional-maxima flag matrix on start and streams it row-major,
// WORD_WIDTH flags per word, over a valid/ready port; done pulses after the last word.
`ifndef CFG_M
`define CFG_M 4
`endif
`ifndef CFG_N
`define CFG_N 4
`endif

module eda_output_reader #(
    parameter int M          = `CFG_M,
    parameter int N          = `CFG_N,
    parameter int WORD_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 start,
    input  logic [M-1:0][N-1:0]  matrix_in,
    eda_output_reader_if.master  dout,
    output logic                 busy,
    output logic                 done,
    output logic                 state_dbg
);
    localparam int NUM_FLAGS = M * N;
    localparam int NUM_WORDS = (NUM_FLAGS + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int IDX_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int PAD_WIDTH = NUM_WORDS * WORD_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t               state_q;
    logic [IDX_WIDTH-1:0] cnt_q;
    logic [M-1:0][N-1:0]  shadow_q;
    logic                 done_q;

    logic                 sending;
    logic                 hs;
    logic [PAD_WIDTH-1:0] padded;

    assign sending = (state_q == SEND);
    assign hs      = sending & dout.dout_ready;

    // Flag p = i*N + j is bit p of the flattened shadow; the tail of the last word is zero.
    always_comb begin
        padded                = '0;
        padded[NUM_FLAGS-1:0] = shadow_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clear) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            shadow_q <= matrix_in;
                            cnt_q    <= '0;
                            state_q  <= SEND;
                        end
                    end
                    SEND: begin
                        if (hs) begin
                            if (cnt_q == LAST_IDX) begin
                                state_q <= IDLE;
                                cnt_q   <= '0;
                                done_q  <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + IDX_WIDTH'(1);
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign dout.dout_valid = sending;
    assign dout.dout_data  = sending ? padded[int'(cnt_q) * WORD_WIDTH +: WORD_WIDTH] : '0;
    assign dout.dout_idx   = sending ? cnt_q : '0;
    assign dout.dout_last  = sending & (cnt_q == LAST_IDX);
    assign busy            = sending;
    assign done            = done_q;
    assign state_dbg       = state_q;
endmodule

// File: tb/tb_eda_output_reader.sv
// Randomized and directed checks of eda_output_reader against a word-list model of the packing rule.
module tb_eda_output_reader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    // Instance A: 4x4 flags, 8 per word (2 words)
    logic            a_start = 1'b0;
    logic [3:0][3:0] a_mat = '0;
    logic            a_busy, a_done, a_st;
    eda_output_reader_if #(.M(4), .N(4), .WORD_WIDTH(8)) a_if ();
    eda_output_reader #(.M(4), .N(4), .WORD_WIDTH(8)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .start(a_start), .matrix_in(a_mat),
        .dout(a_if.master), .busy(a_busy), .done(a_done), .state_dbg(a_st));

    // Instance B: 3x3 flags, 4 per word (3 words, padded)
    logic            b_start = 1'b0;
    logic [2:0][2:0] b_mat = '0;
    logic            b_busy, b_done, b_st;
    eda_output_reader_if #(.M(3), .N(3), .WORD_WIDTH(4)) b_if ();
    eda_output_reader #(.M(3), .N(3), .WORD_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .start(b_start), .matrix_in(b_mat),
        .dout(b_if.master), .busy(b_busy), .done(b_done), .state_dbg(b_st));

    // Instance C: 2x3 flags, 8 per word (single word)
    logic            c_start = 1'b0;
    logic [1:0][2:0] c_mat = '0;
    logic            c_busy, c_done, c_st;
    eda_output_reader_if #(.M(2), .N(3), .WORD_WIDTH(8)) c_if ();
    eda_output_reader #(.M(2), .N(3), .WORD_WIDTH(8)) dut_c (
        .clk(clk), .reset(reset), .clear(clear), .start(c_start), .matrix_in(c_mat),
        .dout(c_if.master), .busy(c_busy), .done(c_done), .state_dbg(c_st));

    initial begin
        a_if.dout_ready = 1'b0;
        b_if.dout_ready = 1'b0;
        c_if.dout_ready = 1'b0;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word k bit b holds flag p = k*w + b; flags beyond nflags read as zero.
    function automatic logic [7:0] model_word(input logic [63:0] flags, input int nflags,
                                              input int w, input int k);
        logic [7:0] r = '0;
        for (int b = 0; b < w; b++) begin
            int p = k * w + b;
            if (p < nflags) r[b] = flags[p];
        end
        return r;
    endfunction

    task automatic build_exp(input logic [63:0] flags, input int nflags, input int w);
        int nw = (nflags + w - 1) / w;
        exp_q.delete();
        for (int k = 0; k < nw; k++) exp_q.push_back(model_word(flags, nflags, w, k));
    endtask

    function automatic logic [63:0] flat_a(input logic [3:0][3:0] m);
        logic [63:0] f = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) f[i*4+j] = m[i][j];
        return f;
    endfunction

    function automatic logic [63:0] flat_b(input logic [2:0][2:0] m);
        logic [63:0] f = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) f[i*3+j] = m[i][j];
        return f;
    endfunction

    // ready_mode: 0 = always 1, 1 = random, 2 = pattern 1,0,0,1
    task automatic run_a(input logic [3:0][3:0] mat, input int ready_mode, input bit mutate);
        int cyc = 0;
        int nw = 2;
        bit hs;
        build_exp(flat_a(mat), 16, 8);
        a_mat = mat;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        if (mutate) a_mat = '0;
        while (exp_q.size() > 0 && cyc < 200) begin
            check("a_valid", 32'(a_if.dout_valid), 32'd1);
            check("a_busy", 32'(a_busy), 32'd1);
            check("a_data", 32'(a_if.dout_data), 32'(exp_q[0]));
            check("a_idx", 32'(a_if.dout_idx), 32'(nw - exp_q.size()));
            check("a_last", 32'(a_if.dout_last), 32'(exp_q.size() == 1));
            case (ready_mode)
                0: a_if.dout_ready = 1'b1;
                1: a_if.dout_ready = 1'($urandom_range(0, 1));
                default: a_if.dout_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
            if (mutate && cyc == 1) a_start = 1'b1;
            hs = a_if.dout_valid && a_if.dout_ready;
            step();
            a_start = 1'b0;
            if (hs) void'(exp_q.pop_front());
            cyc++;
        end
        check("a_drain_in_budget", 32'(exp_q.size()), 32'd0);
        a_if.dout_ready = 1'b0;
        check("a_done_pulse", 32'(a_done), 32'd1);
        check("a_busy_at_done", 32'(a_busy), 32'd0);
        check("a_valid_at_done", 32'(a_if.dout_valid), 32'd0);
        step();
        check("a_done_single", 32'(a_done), 32'd0);
    endtask

    task automatic run_b(input logic [2:0][2:0] mat, input bit rnd_ready);
        int cyc = 0;
        int nw = 3;
        bit hs;
        build_exp(flat_b(mat), 9, 4);
        b_mat = mat;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        while (exp_q.size() > 0 && cyc < 200) begin
            check("b_valid", 32'(b_if.dout_valid), 32'd1);
            check("b_data", 32'(b_if.dout_data), 32'(exp_q[0]));
            check("b_idx", 32'(b_if.dout_idx), 32'(nw - exp_q.size()));
            check("b_last", 32'(b_if.dout_last), 32'(exp_q.size() == 1));
            b_if.dout_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = b_if.dout_valid && b_if.dout_ready;
            step();
            if (hs) void'(exp_q.pop_front());
            cyc++;
        end
        check("b_drain_in_budget", 32'(exp_q.size()), 32'd0);
        b_if.dout_ready = 1'b0;
        check("b_done_pulse", 32'(b_done), 32'd1);
        step();
        check("b_done_single", 32'(b_done), 32'd0);
    endtask

    initial begin
        logic [3:0][3:0] diag;
        logic [3:0][3:0] rm;
        logic [2:0][2:0] rb;
        logic [1:0][2:0] cm;
        diag[0] = 4'b0001; diag[1] = 4'b0010; diag[2] = 4'b0100; diag[3] = 4'b1000;

        // Reset state
        step();
        step();
        check("rst_valid", 32'(a_if.dout_valid), 32'd0);
        check("rst_data", 32'(a_if.dout_data), 32'd0);
        check("rst_idx", 32'(a_if.dout_idx), 32'd0);
        check("rst_last", 32'(a_if.dout_last), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_state", 32'(a_st), 32'd0);
        reset = 1'b0;
        step();
        check("idle_valid", 32'(a_if.dout_valid), 32'd0);

        // Diagonal matrix: words 0x21, 0x84
        run_a(diag, 0, 1'b0);
        check("diag_word0_model", 32'(model_word(flat_a(diag), 16, 8, 0)), 32'h21);
        // Ready toggling 1,0,0,1
        run_a(diag, 2, 1'b0);
        // Input change after start and mid-stream start ignored
        run_a(diag, 0, 1'b1);

        // Back-to-back: start in the done cycle is accepted
        a_mat = diag;
        a_if.dout_ready = 1'b1;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        rm = 16'($urandom);
        step();
        step();
        check("b2b_done", 32'(a_done), 32'd1);
        a_mat = rm;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        check("b2b_valid", 32'(a_if.dout_valid), 32'd1);
        check("b2b_idx", 32'(a_if.dout_idx), 32'd0);
        check("b2b_data0", 32'(a_if.dout_data), 32'(model_word(flat_a(rm), 16, 8, 0)));
        step();
        check("b2b_data1", 32'(a_if.dout_data), 32'(model_word(flat_a(rm), 16, 8, 1)));
        step();
        check("b2b_done2", 32'(a_done), 32'd1);
        a_if.dout_ready = 1'b0;
        step();

        // Clear after first handshake
        a_mat = diag;
        a_if.dout_ready = 1'b1;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        step();
        check("clr_pre_idx", 32'(a_if.dout_idx), 32'd1);
        clear = 1'b1;
        a_if.dout_ready = 1'b0;
        step();
        clear = 1'b0;
        check("clr_valid", 32'(a_if.dout_valid), 32'd0);
        check("clr_busy", 32'(a_busy), 32'd0);
        check("clr_done", 32'(a_done), 32'd0);
        step();
        check("clr_no_done", 32'(a_done), 32'd0);
        run_a(diag, 0, 1'b0);

        // Asynchronous reset mid-stream
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        check("arst_pre_valid", 32'(a_if.dout_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 32'(a_if.dout_valid), 32'd0);
        check("arst_data", 32'(a_if.dout_data), 32'd0);
        check("arst_busy", 32'(a_busy), 32'd0);
        check("arst_last", 32'(a_if.dout_last), 32'd0);
        step();
        reset = 1'b0;
        step();
        check("arst_no_done", 32'(a_done), 32'd0);
        run_a(diag, 0, 1'b0);

        // Random frames on A
        for (int t = 0; t < 8; t++) begin
            rm = 16'($urandom);
            run_a(rm, 1, 1'b0);
        end

        // 3x3, 4 flags per word: all ones -> F, F, 1
        run_b(9'h1FF, 1'b0);
        for (int t = 0; t < 4; t++) begin
            rb = 9'($urandom);
            run_b(rb, 1'b1);
        end

        // Single-word frame: first handshake is also last
        for (int t = 0; t < 3; t++) begin
            cm = 6'($urandom);
            c_mat = cm;
            c_start = 1'b1;
            step();
            c_start = 1'b0;
            check("c_valid", 32'(c_if.dout_valid), 32'd1);
            check("c_last", 32'(c_if.dout_last), 32'd1);
            check("c_idx", 32'(c_if.dout_idx), 32'd0);
            check("c_data", 32'(c_if.dout_data), 32'(model_word(64'(cm), 6, 8, 0)));
            c_if.dout_ready = 1'b1;
            step();
            c_if.dout_ready = 1'b0;
            check("c_done", 32'(c_done), 32'd1);
            check("c_busy", 32'(c_busy), 32'd0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/eda_output_reader.md
# eda_output_reader

Drains the regional-maxima flag matrix produced by the output RAM and streams it to the host side as packed words over a valid/ready interface. On `start` it snapshots the full M×N flag matrix into a shadow register, so the RAM may be cleared for the next image immediately. It then emits the matrix row-major, WORD_WIDTH flags per word, ending with a `last` marker and a `done` pulse. It sits between the output RAM and the result DMA/host bus.

## Interface
- M, `CFG_M: matrix rows
- N, `CFG_N: matrix columns
- WORD_WIDTH, 8: flags packed per output word (1..M*N)
- NUM_WORDS (localparam), ceil(M*N/WORD_WIDTH)
- IDX_WIDTH (localparam), max(1, $clog2(NUM_WORDS))

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous abort; returns block to IDLE, discards snapshot
- start  in  1  single-cycle request to snapshot and stream matrix_in
- matrix_in  in  [M-1:0][N-1:0]  flag matrix from the output RAM
- dout_valid  out  1  dout_data/dout_idx/dout_last valid
- dout_ready  in  1  downstream accepts the word when high with dout_valid
- dout_data  out  WORD_WIDTH  packed flags
- dout_idx  out  IDX_WIDTH  word index, 0..NUM_WORDS-1
- dout_last  out  1  high with the final word (idx = NUM_WORDS-1)
- busy  out  1  high while a stream is in progress (SEND state)
- done  out  1  one-cycle pulse after final word accepted

## Operation
- States: IDLE, SEND. Reset -> IDLE.
- IDLE: start=1 and clear=0 -> capture matrix_in into shadow, word counter := 0, go SEND. Otherwise stay.
- SEND: dout_valid=1. Handshake = dout_valid & dout_ready. On handshake with counter < NUM_WORDS-1: counter += 1. On handshake with counter = NUM_WORDS-1: go IDLE, assert done next cycle.
- start in SEND ignored (no re-snapshot, no queueing).
- clear has priority over start and handshakes: any state -> IDLE, dout_valid=0, counter=0, no done pulse; shadow retains no semantics.
- Packing: flag p = i*N + j maps matrix_in[i][j]; word k bit b carries flag p = k*WORD_WIDTH + b (bit 0 = lowest p). Bits with p >= M*N are 0.
- dout_data, dout_idx, dout_last are combinational from shadow and counter in SEND; forced 0 in IDLE.
- Shadow is not updated while streaming; changes on matrix_in during SEND have no effect.

## Timing
- Reset values: dout_valid=0, dout_data=0, dout_idx=0, dout_last=0, busy=0, done=0, state IDLE, counter 0, shadow all 0.
- start sampled at edge t -> dout_valid=1 with word 0 from cycle t+1 (1-cycle latency).
- With dout_ready held high: one word per cycle, NUM_WORDS cycles total; done high in the cycle following the last handshake, busy low in that same cycle.
- dout_ready low: dout_valid stays high, data/idx/last held stable (AXI-style; valid never drops without handshake except on clear/reset).
- start in the same cycle as done (state IDLE) is accepted; back-to-back frames gap is exactly one cycle.
- Reset mid-stream: outputs return to reset values asynchronously; no done.
- NUM_WORDS=1: first handshake is also last; dout_last high in cycle t+1.

## Test plan
- M=4,N=4,WORD_WIDTH=8, matrix rows 0..3 = 4'b0001,4'b0010,4'b0100,4'b1000 ([i][j], j=bit), start, ready=1 -> words 0x21, 0x84, idx 0,1, last on idx 1, done one cycle later.
- M=3,N=3,WORD_WIDTH=4, all flags 1 -> words 0xF, 0xF, 0x1 (padding zeros), last on third word.
- Same as first case with dout_ready toggling 1,0,0,1 -> each word held stable while ready=0; exactly 2 handshakes, no duplicates.
- Change matrix_in to all 0 one cycle after start -> streamed words still match snapshot (0x21, 0x84); start pulsed mid-stream ignored.
- Assert clear after first handshake -> dout_valid=0 next cycle, no done; new start restarts at idx 0.
- Assert reset while dout_valid=1 -> all outputs 0 immediately; after release, start streams normally.
